// File: rtl/depar_seg_merge_if.sv
// depar_seg_merge_if: FIFO-side inputs and m_axis output bundle of the segment merge stage
interface depar_seg_merge_if #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS         = 4
);
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int KW = C_AXIS_DATA_WIDTH/8;
  localparam int H  = C_NUM_SEGS/2;
  logic [DW*H-1:0] fst_half_tdata, snd_half_tdata;
  logic [UW*H-1:0] fst_half_tuser, snd_half_tuser;
  logic [KW*H-1:0] fst_half_tkeep, snd_half_tkeep;
  logic [H-1:0]    fst_half_tlast, snd_half_tlast;
  logic            fst_half_empty, snd_half_empty, fst_half_rd_en, snd_half_rd_en;
  logic [DW-1:0]   seg_fifo_tdata, m_axis_tdata;
  logic [UW-1:0]   seg_fifo_tuser, m_axis_tuser;
  logic [KW-1:0]   seg_fifo_tkeep, m_axis_tkeep;
  logic            seg_fifo_tlast, seg_fifo_empty, seg_fifo_rd_en;
  logic            m_axis_tlast, m_axis_tvalid, m_axis_tready;
  modport slave (
    input  fst_half_tdata, fst_half_tuser, fst_half_tkeep, fst_half_tlast, fst_half_empty,
    input  snd_half_tdata, snd_half_tuser, snd_half_tkeep, snd_half_tlast, snd_half_empty,
    input  seg_fifo_tdata, seg_fifo_tuser, seg_fifo_tkeep, seg_fifo_tlast, seg_fifo_empty,
    output fst_half_rd_en, snd_half_rd_en, seg_fifo_rd_en,
    output m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );
  modport master (
    output fst_half_tdata, fst_half_tuser, fst_half_tkeep, fst_half_tlast, fst_half_empty,
    output snd_half_tdata, snd_half_tuser, snd_half_tkeep, snd_half_tlast, snd_half_empty,
    output seg_fifo_tdata, seg_fifo_tuser, seg_fifo_tkeep, seg_fifo_tlast, seg_fifo_empty,
    input  fst_half_rd_en, snd_half_rd_en, seg_fifo_rd_en,
    input  m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/depar_seg_merge.sv
// depar_seg_merge: reassembles split packet halves and spill segments into one segment-per-beat AXI-Stream
module depar_seg_merge #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS         = 4
) (
  input  logic             clk,
  input  logic             aresetn,
  depar_seg_merge_if.slave bus,
  output logic [31:0]      pkt_cnt
);
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int KW = C_AXIS_DATA_WIDTH/8;
  localparam int H  = C_NUM_SEGS/2;
  typedef enum logic [2:0] {EMIT_FST0, EMIT_FST1, EMIT_SND0, EMIT_SND1, FLUSH, DISCARD_SND} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] tdata_q, seg_data;
  logic [UW-1:0] tuser_q, seg_user;
  logic [KW-1:0] tkeep_q, seg_keep;
  logic          tlast_q, tvalid_q, seg_last, src_empty, ld, go, adv;
  logic          f0, f1, s0, s1, fl, dis;
  logic [31:0]   pkt_cnt_q;
  // Pick the current segment slot, decide whether it can be loaded, and where to go next
  always_comb begin
    f0 = state_q == EMIT_FST0;
    f1 = state_q == EMIT_FST1;
    s0 = state_q == EMIT_SND0;
    s1 = state_q == EMIT_SND1;
    fl = state_q == FLUSH;
    dis = state_q == DISCARD_SND;
    seg_data = f0 ? bus.fst_half_tdata[DW-1:0] : f1 ? bus.fst_half_tdata[H*DW-1 -: DW] :
               s0 ? bus.snd_half_tdata[DW-1:0] : s1 ? bus.snd_half_tdata[H*DW-1 -: DW] : bus.seg_fifo_tdata;
    seg_user = f0 ? bus.fst_half_tuser[UW-1:0] : f1 ? bus.fst_half_tuser[H*UW-1 -: UW] :
               s0 ? bus.snd_half_tuser[UW-1:0] : s1 ? bus.snd_half_tuser[H*UW-1 -: UW] : bus.seg_fifo_tuser;
    seg_keep = f0 ? bus.fst_half_tkeep[KW-1:0] : f1 ? bus.fst_half_tkeep[H*KW-1 -: KW] :
               s0 ? bus.snd_half_tkeep[KW-1:0] : s1 ? bus.snd_half_tkeep[H*KW-1 -: KW] : bus.seg_fifo_tkeep;
    seg_last = f0 ? bus.fst_half_tlast[0] : f1 ? bus.fst_half_tlast[H-1] :
               s0 ? bus.snd_half_tlast[0] : s1 ? bus.snd_half_tlast[H-1] : bus.seg_fifo_tlast;
    src_empty = (f0 || f1) ? bus.fst_half_empty : (s0 || s1) ? bus.snd_half_empty :
                fl ? bus.seg_fifo_empty : 1'b1;
    ld = !tvalid_q || bus.m_axis_tready;
    go = ld && !src_empty;
    adv = go || (dis && !bus.snd_half_empty);
    state_d = state_q;
    case (state_q)
      EMIT_FST0:   state_d = seg_last ? DISCARD_SND : EMIT_FST1;
      EMIT_FST1:   state_d = seg_last ? DISCARD_SND : EMIT_SND0;
      EMIT_SND0:   state_d = seg_last ? EMIT_FST0 : EMIT_SND1;
      EMIT_SND1:   state_d = seg_last ? EMIT_FST0 : FLUSH;
      FLUSH:       state_d = seg_last ? EMIT_FST0 : FLUSH;
      default:     state_d = EMIT_FST0;
    endcase
  end
  assign bus.fst_half_rd_en = go && ((f0 && seg_last) || f1);
  assign bus.snd_half_rd_en = (go && ((s0 && seg_last) || s1)) || (dis && !bus.snd_half_empty);
  assign bus.seg_fifo_rd_en = go && fl;
  assign bus.m_axis_tdata   = tdata_q;
  assign bus.m_axis_tuser   = tuser_q;
  assign bus.m_axis_tkeep   = tkeep_q;
  assign bus.m_axis_tlast   = tlast_q;
  assign bus.m_axis_tvalid  = tvalid_q;
  assign pkt_cnt            = pkt_cnt_q;
  // Advance the FSM, load the output register on a load slot, and count completed packets
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      state_q   <= EMIT_FST0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tuser_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      if (adv) state_q <= state_d;
      if (go) begin
        tvalid_q <= 1'b1;
        tdata_q  <= seg_data;
        tuser_q  <= seg_user;
        tkeep_q  <= seg_keep;
        tlast_q  <= seg_last;
      end else if (bus.m_axis_tready) tvalid_q <= 1'b0;
      if (tvalid_q && bus.m_axis_tready && tlast_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
endmodule

// File: tb/tb_depar_seg_merge.sv
// tb_depar_seg_merge: directed scenarios for the segment merge stage with FWFT FIFO models
module tb_depar_seg_merge;
  localparam int DW = 256, UW = 128, KW = 32;
  logic clk = 1'b0, aresetn = 1'b0;
  logic [31:0] pkt_cnt;
  int n_cmp = 0, n_fail = 0;
  depar_seg_merge_if bus ();
  depar_seg_merge dut (.clk(clk), .aresetn(aresetn), .bus(bus), .pkt_cnt(pkt_cnt));
  always #5 clk = ~clk;

  logic [2*DW-1:0] fst_d [16], snd_d [16];
  logic [2*UW-1:0] fst_u [16], snd_u [16];
  logic [2*KW-1:0] fst_k [16], snd_k [16];
  logic [1:0]      fst_l [16], snd_l [16];
  logic [DW-1:0]   seg_d [16];
  logic [UW-1:0]   seg_u [16];
  logic [KW-1:0]   seg_k [16];
  logic            seg_l [16];
  int fst_wp = 0, fst_rp = 0, snd_wp = 0, snd_rp = 0, seg_wp = 0, seg_rp = 0;
  assign bus.fst_half_empty = fst_wp == fst_rp;
  assign bus.fst_half_tdata = fst_d[fst_rp[3:0]];
  assign bus.fst_half_tuser = fst_u[fst_rp[3:0]];
  assign bus.fst_half_tkeep = fst_k[fst_rp[3:0]];
  assign bus.fst_half_tlast = fst_l[fst_rp[3:0]];
  assign bus.snd_half_empty = snd_wp == snd_rp;
  assign bus.snd_half_tdata = snd_d[snd_rp[3:0]];
  assign bus.snd_half_tuser = snd_u[snd_rp[3:0]];
  assign bus.snd_half_tkeep = snd_k[snd_rp[3:0]];
  assign bus.snd_half_tlast = snd_l[snd_rp[3:0]];
  assign bus.seg_fifo_empty = seg_wp == seg_rp;
  assign bus.seg_fifo_tdata = seg_d[seg_rp[3:0]];
  assign bus.seg_fifo_tuser = seg_u[seg_rp[3:0]];
  assign bus.seg_fifo_tkeep = seg_k[seg_rp[3:0]];
  assign bus.seg_fifo_tlast = seg_l[seg_rp[3:0]];

  int cyc = 0, rec_n = 0, fst_pops = 0, snd_pops = 0, seg_pops = 0;
  int multi_rd = 0, bp_pop = 0, stab_err = 0, stalls = 0;
  logic [DW-1:0] rec_d [64];
  logic [UW-1:0] rec_u [64];
  logic [KW-1:0] rec_k [64];
  logic          rec_l [64];
  int            rec_c [64];
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fst_half_rd_en) begin fst_rp <= fst_rp + 1; fst_pops <= fst_pops + 1; end
    if (bus.snd_half_rd_en) begin snd_rp <= snd_rp + 1; snd_pops <= snd_pops + 1; end
    if (bus.seg_fifo_rd_en) begin seg_rp <= seg_rp + 1; seg_pops <= seg_pops + 1; end
    if ($countones({bus.fst_half_rd_en, bus.snd_half_rd_en, bus.seg_fifo_rd_en}) > 1) multi_rd <= multi_rd + 1;
    if (bus.m_axis_tvalid && !bus.m_axis_tready) begin
      stalls <= stalls + 1;
      if (bus.fst_half_rd_en || bus.snd_half_rd_en || bus.seg_fifo_rd_en) bp_pop <= bp_pop + 1;
    end
    if (held_v && (!bus.m_axis_tvalid || bus.m_axis_tdata !== held_d)) stab_err <= stab_err + 1;
    held_v <= bus.m_axis_tvalid && !bus.m_axis_tready && aresetn;
    held_d <= bus.m_axis_tdata;
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      rec_d[rec_n[5:0]] <= bus.m_axis_tdata;
      rec_u[rec_n[5:0]] <= bus.m_axis_tuser;
      rec_k[rec_n[5:0]] <= bus.m_axis_tkeep;
      rec_l[rec_n[5:0]] <= bus.m_axis_tlast;
      rec_c[rec_n[5:0]] <= cyc;
      rec_n <= rec_n + 1;
    end
  end

  function automatic logic [DW-1:0] sd(int p, int s);
    return {8{p[15:0], s[15:0]}};
  endfunction
  function automatic logic [UW-1:0] su(int p, int s);
    return {4{s[15:0], p[15:0]}};
  endfunction
  function automatic logic [KW-1:0] sk(logic l);
    return l ? 32'h0000_ffff : 32'hffff_ffff;
  endfunction

  task automatic push_fst(int p, logic [1:0] l);
    fst_d[fst_wp[3:0]] = {sd(p, 1), sd(p, 0)};
    fst_u[fst_wp[3:0]] = {su(p, 1), su(p, 0)};
    fst_k[fst_wp[3:0]] = {sk(l[1]), sk(l[0])};
    fst_l[fst_wp[3:0]] = l;
    fst_wp++;
  endtask
  task automatic push_snd(int p, logic [1:0] l);
    snd_d[snd_wp[3:0]] = {sd(p, 3), sd(p, 2)};
    snd_u[snd_wp[3:0]] = {su(p, 3), su(p, 2)};
    snd_k[snd_wp[3:0]] = {sk(l[1]), sk(l[0])};
    snd_l[snd_wp[3:0]] = l;
    snd_wp++;
  endtask
  task automatic push_seg(int p, int s, logic l);
    seg_d[seg_wp[3:0]] = sd(p, s);
    seg_u[seg_wp[3:0]] = su(p, s);
    seg_k[seg_wp[3:0]] = sk(l);
    seg_l[seg_wp[3:0]] = l;
    seg_wp++;
  endtask
  task automatic wait_beats(int base, int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = rec_n - base >= n;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    bus.m_axis_tready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tkeep} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: tvalid=%b tlast=%b tkeep=%h, need all zero", bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tkeep);
    end
    n_cmp++;
    if (pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d need 0", pkt_cnt); end
    n_cmp++;
    if ({bus.fst_half_rd_en, bus.snd_half_rd_en, bus.seg_fifo_rd_en} !== 3'b000) begin
      n_fail++; $display("FAIL reset_rd_en: got %b need 000", {bus.fst_half_rd_en, bus.snd_half_rd_en, bus.seg_fifo_rd_en});
    end
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_one_seg();
    int base = rec_n, pf = fst_pops, ps = snd_pops;
    bit ok;
    push_fst(1, 2'b01);
    push_snd(90, 2'b00);
    @(posedge clk); #1;
    n_cmp++;
    if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== sd(1, 0) || bus.m_axis_tlast !== 1'b1) begin
      n_fail++; $display("FAIL one_seg_latency: tvalid=%b tlast=%b d=%h need 1/1/%h", bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, sd(1, 0));
    end
    wait_beats(base, 1, ok);
    n_cmp++;
    if (!ok || rec_n - base != 1) begin n_fail++; $display("FAIL one_seg_count: got %0d beats need 1", rec_n - base); end
    n_cmp++;
    if (rec_d[base[5:0]] !== sd(1, 0) || rec_u[base[5:0]] !== su(1, 0) || rec_k[base[5:0]] !== sk(1'b1) || rec_l[base[5:0]] !== 1'b1) begin
      n_fail++; $display("FAIL one_seg_beat: d=%h k=%h l=%b need %h %h 1", rec_d[base[5:0]], rec_k[base[5:0]], rec_l[base[5:0]], sd(1, 0), sk(1'b1));
    end
    n_cmp++;
    if (fst_pops - pf != 1 || snd_pops - ps != 1) begin n_fail++; $display("FAIL one_seg_pops: fst=%0d snd=%0d need 1 1", fst_pops - pf, snd_pops - ps); end
    n_cmp++;
    if (pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL one_seg_pkt_cnt: got %0d need 1", pkt_cnt); end
  endtask

  task automatic test_three_seg();
    int base = rec_n, pf = fst_pops, ps = snd_pops, pc = pkt_cnt;
    bit ok;
    push_fst(2, 2'b00);
    push_snd(2, 2'b01);
    wait_beats(base, 3, ok);
    n_cmp++;
    if (!ok || rec_n - base != 3) begin n_fail++; $display("FAIL three_seg_count: got %0d beats need 3", rec_n - base); end
    for (int i = 0; i < 3; i++) begin
      int j = (base + i) % 64;
      n_cmp++;
      if (rec_d[j] !== sd(2, i) || rec_u[j] !== su(2, i) || rec_k[j] !== sk(i == 2) || rec_l[j] !== (i == 2)) begin
        n_fail++; $display("FAIL three_seg_beat%0d: d=%h l=%b need %h %b", i, rec_d[j], rec_l[j], sd(2, i), i == 2);
      end
    end
    n_cmp++;
    if (rec_c[(base + 2) % 64] - rec_c[base % 64] != 2) begin n_fail++; $display("FAIL three_seg_back2back: span %0d need 2", rec_c[(base + 2) % 64] - rec_c[base % 64]); end
    n_cmp++;
    if (fst_pops - pf != 1 || snd_pops - ps != 1 || pkt_cnt - pc != 1) begin
      n_fail++; $display("FAIL three_seg_pops: fst=%0d snd=%0d pkts=%0d need 1 1 1", fst_pops - pf, snd_pops - ps, pkt_cnt - pc);
    end
  endtask

  task automatic test_six_seg();
    int base = rec_n, pg = seg_pops, pc = pkt_cnt;
    bit ok;
    push_fst(3, 2'b00);
    push_snd(3, 2'b00);
    push_seg(3, 4, 1'b0);
    push_seg(3, 5, 1'b1);
    wait_beats(base, 6, ok);
    n_cmp++;
    if (!ok || rec_n - base != 6) begin n_fail++; $display("FAIL six_seg_count: got %0d beats need 6", rec_n - base); end
    for (int i = 0; i < 6; i++) begin
      int j = (base + i) % 64;
      n_cmp++;
      if (rec_d[j] !== sd(3, i) || rec_u[j] !== su(3, i) || rec_k[j] !== sk(i == 5) || rec_l[j] !== (i == 5)) begin
        n_fail++; $display("FAIL six_seg_beat%0d: d=%h l=%b need %h %b", i, rec_d[j], rec_l[j], sd(3, i), i == 5);
      end
    end
    n_cmp++;
    if (rec_c[(base + 5) % 64] - rec_c[base % 64] != 5) begin n_fail++; $display("FAIL six_seg_back2back: span %0d need 5", rec_c[(base + 5) % 64] - rec_c[base % 64]); end
    n_cmp++;
    if (seg_pops - pg != 2 || pkt_cnt - pc != 1) begin n_fail++; $display("FAIL six_seg_pops: seg=%0d pkts=%0d need 2 1", seg_pops - pg, pkt_cnt - pc); end
  endtask

  task automatic test_backpressure();
    int base = rec_n, s0 = stab_err, b0 = bp_pop, st0 = stalls, pc = pkt_cnt;
    logic [3:0] pat = 4'b1001;
    bit ok = 1'b0;
    push_fst(4, 2'b00);
    push_snd(4, 2'b10);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      bus.m_axis_tready = pat[i % 4];
      ok = rec_n - base >= 4;
    end
    bus.m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!ok || rec_n - base != 4) begin n_fail++; $display("FAIL bp_count: got %0d beats need 4", rec_n - base); end
    for (int i = 0; i < 4; i++) begin
      int j = (base + i) % 64;
      n_cmp++;
      if (rec_d[j] !== sd(4, i) || rec_u[j] !== su(4, i) || rec_k[j] !== sk(i == 3) || rec_l[j] !== (i == 3)) begin
        n_fail++; $display("FAIL bp_beat%0d: d=%h l=%b need %h %b", i, rec_d[j], rec_l[j], sd(4, i), i == 3);
      end
    end
    n_cmp++;
    if (stalls - st0 < 1) begin n_fail++; $display("FAIL bp_stalled: got %0d stall cycles need >0", stalls - st0); end
    n_cmp++;
    if (stab_err != s0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles need 0", stab_err - s0); end
    n_cmp++;
    if (bp_pop != b0) begin n_fail++; $display("FAIL bp_no_pop: got %0d pops while stalled need 0", bp_pop - b0); end
    n_cmp++;
    if (pkt_cnt - pc != 1) begin n_fail++; $display("FAIL bp_pkt_cnt: got +%0d need +1", pkt_cnt - pc); end
  endtask

  task automatic test_back_to_back();
    int base = rec_n, pf = fst_pops, ps = snd_pops, pg = seg_pops, pc = pkt_cnt;
    bit ok;
    push_fst(5, 2'b10);
    push_fst(6, 2'b00);
    push_seg(6, 4, 1'b1);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (snd_pops != ps || rec_n - base != 2 || bus.m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_discard_wait: snd_pops=%0d beats=%0d tvalid=%b need 0 2 0", snd_pops - ps, rec_n - base, bus.m_axis_tvalid);
    end
    push_snd(91, 2'b00);
    push_snd(6, 2'b00);
    wait_beats(base, 7, ok);
    n_cmp++;
    if (!ok || rec_n - base != 7) begin n_fail++; $display("FAIL b2b_count: got %0d beats need 7", rec_n - base); end
    for (int i = 0; i < 7; i++) begin
      int j = (base + i) % 64;
      int p = i < 2 ? 5 : 6;
      int s = i < 2 ? i : i - 2;
      logic l = (i == 1) || (i == 6);
      n_cmp++;
      if (rec_d[j] !== sd(p, s) || rec_u[j] !== su(p, s) || rec_k[j] !== sk(l) || rec_l[j] !== l) begin
        n_fail++; $display("FAIL b2b_beat%0d: d=%h l=%b need %h %b", i, rec_d[j], rec_l[j], sd(p, s), l);
      end
    end
    n_cmp++;
    if (rec_c[(base + 2) % 64] - rec_c[(base + 1) % 64] != 5) begin
      n_fail++; $display("FAIL b2b_gap: got %0d cycles need 5", rec_c[(base + 2) % 64] - rec_c[(base + 1) % 64]);
    end
    n_cmp++;
    if (fst_pops - pf != 2 || snd_pops - ps != 2 || seg_pops - pg != 1 || pkt_cnt - pc != 2) begin
      n_fail++; $display("FAIL b2b_pops: fst=%0d snd=%0d seg=%0d pkts=%0d need 2 2 1 2", fst_pops - pf, snd_pops - ps, seg_pops - pg, pkt_cnt - pc);
    end
    n_cmp++;
    if (multi_rd != 0) begin n_fail++; $display("FAIL one_rd_en: got %0d multi-pop cycles need 0", multi_rd); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    push_fst(7, 2'b00);
    push_snd(7, 2'b10);
    @(posedge clk);
    @(posedge clk); #2;
    n_cmp++;
    if (bus.m_axis_tvalid !== 1'b1 || pkt_cnt !== 32'd6) begin
      n_fail++; $display("FAIL mid_pre_reset: tvalid=%b pkt_cnt=%0d need 1 6", bus.m_axis_tvalid, pkt_cnt);
    end
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdata !== '0 || pkt_cnt !== 32'd0) begin
      n_fail++; $display("FAIL mid_async_reset: tvalid=%b pkt_cnt=%0d need 0 0", bus.m_axis_tvalid, pkt_cnt);
    end
    snd_wp = snd_rp;
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    base = rec_n;
    push_fst(8, 2'b01);
    push_snd(92, 2'b00);
    wait_beats(base, 1, ok);
    n_cmp++;
    if (!ok || rec_n - base != 1 || rec_d[base[5:0]] !== sd(8, 0) || rec_l[base[5:0]] !== 1'b1) begin
      n_fail++; $display("FAIL mid_restart_beat: beats=%0d d=%h need 1 %h", rec_n - base, rec_d[base[5:0]], sd(8, 0));
    end
    n_cmp++;
    if (pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL mid_restart_pkt_cnt: got %0d need 1", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_one_seg();
    test_three_seg();
    test_six_seg();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/depar_seg_merge.md
Name: depar_seg_merge

Overview:
- Output stage directly downstream of the deparser segment-split stage.
- Reassembles each packet into one AXI-Stream at one 256-bit segment per beat, in order:
  - segments 0–1 come from the first-half FIFO entry;
  - segments 2–3 come from the second-half FIFO entry;
  - segments 4 and above come from the remaining-segment FIFO.
- Discards the dummy second-half entry the split stage pushes for 1- and 2-segment packets.
- Drives the pipeline's final m_axis output.

Parameters:
C_AXIS_DATA_WIDTH, 256, segment data width
C_AXIS_TUSER_WIDTH, 128, per-segment tuser width
C_NUM_SEGS, 4, number of segments held in the two half FIFOs (2 per half)

Ports:
clk  in  1  clock
aresetn  in  1  reset; asynchronous, active-low
fst_half_tdata  in  C_AXIS_DATA_WIDTH*C_NUM_SEGS/2  seg0 at [255:0], seg1 at [511:256]
fst_half_tuser  in  C_AXIS_TUSER_WIDTH*C_NUM_SEGS/2  per-segment tuser, same packing
fst_half_tkeep  in  C_AXIS_DATA_WIDTH/8*C_NUM_SEGS/2  per-segment tkeep, same packing
fst_half_tlast  in  C_NUM_SEGS/2  bit i = segment i is last
fst_half_empty  in  1  first-half FIFO (FWFT) empty
fst_half_rd_en  out  1  pop first-half FIFO
snd_half_tdata/tuser/tkeep/tlast/empty  in  same widths as fst_half_*  segments 2,3
snd_half_rd_en  out  1  pop second-half FIFO
seg_fifo_tdata  in  C_AXIS_DATA_WIDTH  remaining-segment data
seg_fifo_tuser  in  C_AXIS_TUSER_WIDTH  remaining-segment tuser
seg_fifo_tkeep  in  C_AXIS_DATA_WIDTH/8  remaining-segment tkeep
seg_fifo_tlast  in  1  remaining-segment last flag
seg_fifo_empty  in  1  remaining-segment FIFO (FWFT) empty
seg_fifo_rd_en  out  1  pop remaining-segment FIFO
m_axis_tdata  out  C_AXIS_DATA_WIDTH  output beat data
m_axis_tuser  out  C_AXIS_TUSER_WIDTH  output beat tuser
m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  output beat tkeep
m_axis_tlast  out  1  output beat last
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready
pkt_cnt  out  32  packets fully emitted; wraps modulo 2^32

Behaviour:
- Reset (async, aresetn low):
  - State goes to EMIT_FST0.
  - All m_axis_* outputs = 0 and pkt_cnt = 0.
  - Any partial packet is abandoned; flushing the FIFOs is the system's job.
- All three input FIFOs are first-word-fall-through. The rd_en outputs are combinational from state and inputs, and a pop takes effect on the same clock edge.
- Output register:
  - ld = !m_axis_tvalid || m_axis_tready.
  - A beat is loaded only when ld=1 and the current source is non-empty; then tvalid<=1 with data, tuser, tkeep and tlast copied from the selected segment.
  - Otherwise, if m_axis_tready=1, tvalid<=0.
  - Data is held stable while tvalid && !tready.
- Latency: 1 clk from source non-empty to m_axis_tvalid. Sustains 1 beat/clk while tready stays high.
- pkt_cnt increments on every cycle with m_axis_tvalid && m_axis_tready && m_axis_tlast.
- States and transitions (transitions fire only on a load):
  - EMIT_FST0: source is fst seg0.
    - If fst_half_tlast[0]: fst_half_rd_en=1 → DISCARD_SND.
    - Else → EMIT_FST1 (no pop).
  - EMIT_FST1: source is fst seg1; fst_half_rd_en=1.
    - If fst_half_tlast[1] → DISCARD_SND.
    - Else → EMIT_SND0.
  - EMIT_SND0: source is snd seg0.
    - If snd_half_tlast[0]: snd_half_rd_en=1 → EMIT_FST0.
    - Else → EMIT_SND1.
  - EMIT_SND1: source is snd seg1; snd_half_rd_en=1.
    - If snd_half_tlast[1] → EMIT_FST0.
    - Else → FLUSH.
  - FLUSH: source is seg_fifo; seg_fifo_rd_en=1.
    - If seg_fifo_tlast → EMIT_FST0.
    - Otherwise stay in FLUSH.
  - DISCARD_SND: no output beat and no dependence on ld.
    - When !snd_half_empty: snd_half_rd_en=1 → EMIT_FST0.
    - Otherwise wait.
- Boundary conditions:
  - An empty source stalls in the current state with no pop, and no beat is loaded.
  - Backpressure (ld=0) means no pop and no state change.
  - At most one rd_en is asserted per cycle.
  - The tkeep, tuser and tlast of each segment pass through unmodified. Segments after a tlast within the same half entry are dropped.

Test Plan:
1. 1-seg pkt: fst entry tlast=2'b01 plus dummy snd entry, tready=1 → one beat with tlast=1, tvalid 1 clk after non-empty; fst and snd each popped once; pkt_cnt=1.
2. 3-seg pkt: fst tlast=2'b00, snd tlast=2'b01 → 3 consecutive beats with seg0, seg1, seg2 data; tlast on beat 3 only; fst popped on beat 2, snd on beat 3.
3. 6-seg pkt: fst and snd entries full, seg_fifo holds 2 beats (2nd has tlast) → 6 beats in order; seg_fifo popped twice; state back at EMIT_FST0.
4. Backpressure: 4-seg pkt with tready toggling 1,0,0,1,… → tdata stable while stalled; no beat lost or duplicated; rd_en only on loads.
5. Back-to-back: 2-seg pkt then 5-seg pkt, snd dummy entry arriving 3 clks late → DISCARD_SND waits 3 clks, then 7 beats total; pkt_cnt=2.
6. Reset mid-packet: assert aresetn=0 during EMIT_SND0 → tvalid drops immediately (async); after release, state is EMIT_FST0 and pkt_cnt=0.
